// File: rtl/ysyx_22050058_mul.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, full 2*WIDTH product.
// Signed operands are multiplied as magnitudes and the product is negated at the end.
module ysyx_22050058_mul #(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             mul_valid_i,
    output logic             mul_ready_o,
    input  logic [1:0]       mul_signed_i,
    input  logic [WIDTH-1:0] multiplicand_i,
    input  logic [WIDTH-1:0] multiplier_i,
    input  logic             flush_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] result_hi_o,
    output logic [WIDTH-1:0] result_lo_o
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH-1:0] OneW = WIDTH'(1);

    typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

    state_e             r_state;
    logic               r_sign_a;
    logic               r_sign_b;
    logic [2*WIDTH-1:0] r_mag_a_sh;
    logic [WIDTH-1:0]   r_mag_b;
    logic [2*WIDTH-1:0] r_acc;
    logic [CntW-1:0]    r_cnt;
    logic               r_out_valid;
    logic [WIDTH-1:0]   r_res_hi;
    logic [WIDTH-1:0]   r_res_lo;

    logic               w_sign_a;
    logic               w_sign_b;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic [2*WIDTH-1:0] w_prod;

    assign mul_ready_o = (r_state == StIdle) && !rst_i;
    assign out_valid_o = r_out_valid;
    assign result_hi_o = r_res_hi;
    assign result_lo_o = r_res_lo;

    // A most-negative operand negates to 2^(WIDTH-1), which is exact as an unsigned magnitude.
    assign w_sign_a = mul_signed_i[1] & multiplicand_i[WIDTH-1];
    assign w_sign_b = mul_signed_i[0] & multiplier_i[WIDTH-1];
    assign w_mag_a  = w_sign_a ? (~multiplicand_i + OneW) : multiplicand_i;
    assign w_mag_b  = w_sign_b ? (~multiplier_i + OneW) : multiplier_i;
    assign w_prod   = (r_sign_a ^ r_sign_b) ? -r_acc : r_acc;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= StIdle;
            r_sign_a    <= 1'b0;
            r_sign_b    <= 1'b0;
            r_mag_a_sh  <= '0;
            r_mag_b     <= '0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_res_hi    <= '0;
            r_res_lo    <= '0;
        end else if (flush_i) begin
            r_state     <= StIdle;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (mul_valid_i) begin
                        r_sign_a   <= w_sign_a;
                        r_sign_b   <= w_sign_b;
                        r_mag_a_sh <= {{WIDTH{1'b0}}, w_mag_a};
                        r_mag_b    <= w_mag_b;
                        r_acc      <= '0;
                        r_cnt      <= '0;
                        r_state    <= StCalc;
                    end
                end
                StCalc: begin
                    // Multiplicand is pre-shifted by the counter; multiplier consumed LSB first.
                    if (r_mag_b[0]) begin
                        r_acc <= r_acc + r_mag_a_sh;
                    end
                    r_mag_a_sh <= r_mag_a_sh << 1;
                    r_mag_b    <= r_mag_b >> 1;
                    r_cnt      <= r_cnt + CntW'(1);
                    if (r_cnt == CntW'(WIDTH - 1)) begin
                        r_state <= StFix;
                    end
                end
                StFix: begin
                    r_res_hi    <= w_prod[2*WIDTH-1:WIDTH];
                    r_res_lo    <= w_prod[WIDTH-1:0];
                    r_out_valid <= 1'b1;
                    r_state     <= StDone;
                end
                StDone: begin
                    if (out_ready_i) begin
                        r_out_valid <= 1'b0;
                        r_state     <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

endmodule

// File: doc/ysyx_22050058_mul.md
# ysyx_22050058_mul

Iterative shift-add integer multiplier for the EXU's M-extension multiply path; the mirror-image arithmetic unit to the pipelined divider. It accepts one operand pair through a valid/ready handshake and computes the full 2×WIDTH-bit product over a fixed number of cycles. The product is returned as separate high and low halves so the EXU can select MUL, MULH, MULHSU or MULHU. Signed and unsigned operands are handled by magnitude conversion plus a final conditional negation.

## Interface
- WIDTH, 64, operand width; product is 2*WIDTH bits
- clk_i  input  1  single clock; all state updates on rising edge
- rst_i  input  1  synchronous reset, active-high
- mul_valid_i  input  1  request valid
- mul_ready_o  output  1  unit idle and able to accept a request
- mul_signed_i  input  2  [1]: multiplicand signed, [0]: multiplier signed (11=MULH, 10=MULHSU, 00=MULHU/MUL, 01 legal)
- multiplicand_i  input  WIDTH  operand A (rs1)
- multiplier_i  input  WIDTH  operand B (rs2)
- flush_i  input  1  abort any in-flight operation (pipeline flush)
- out_valid_o  output  1  result valid
- out_ready_i  input  1  consumer accepts result
- result_hi_o  output  WIDTH  product bits [2*WIDTH-1:WIDTH]
- result_lo_o  output  WIDTH  product bits [WIDTH-1:0]

## Operation
- FSM states: IDLE, CALC, FIX, DONE.
- mul_ready_o = (state==IDLE) && !rst_i. Requests are accepted only on an edge where mul_valid_i && mul_ready_o && !flush_i.
- Accept, IDLE->CALC:
  - latch sign_a = mul_signed_i[1] & A[WIDTH-1] and sign_b = mul_signed_i[0] & B[WIDTH-1];
  - latch |A| and |B| as two's-complement magnitudes when the sign bit is set, raw value otherwise;
  - clear the 2W-bit accumulator and the cycle counter.
- Most-negative operand: its magnitude is 2^(WIDTH-1); that value is exact as unsigned WIDTH bits, so no special case is needed.
- CALC, one multiplier bit per cycle, LSB first:
  - if the current bit is 1, accumulator += (|A| << counter);
  - counter++.
  - After WIDTH CALC cycles, go to FIX. There is no early termination; zero operands take full latency.
- FIX: if sign_a ^ sign_b, the product becomes the 2W-bit two's-complement negation. Load result_hi_o/result_lo_o, then go to DONE.
- DONE: out_valid_o=1 and the results are held stable until out_valid_o && out_ready_i. On that edge go to IDLE.
- flush_i:
  - In any state, the next edge goes to IDLE and out_valid_o goes to 0.
  - flush_i takes priority over a same-cycle accept and over a same-cycle result handshake.
  - result_hi_o/result_lo_o keep their last values and are don't-care while out_valid_o=0.
- New requests are ignored while busy; there is no queueing. The requester must hold mul_valid_i until accepted.

## Timing
- Reset (rst_i high at an edge):
  - state=IDLE, out_valid_o=0, result_hi_o=0, result_lo_o=0, counter=0, accumulator=0.
  - mul_ready_o=0 while rst_i is high and 1 in the first cycle after rst_i drops.
- Reset mid-operation discards the operation; no output handshake occurs.
- Latency: with the accept edge as E0, CALC occupies E1..E_WIDTH, FIX is E_WIDTH+1, and out_valid_o is high from E_WIDTH+1 onward (WIDTH+1 edges after accept; 65 for WIDTH=64).
- Throughput: back-to-back operation requires the handshake at edge Eh. mul_ready_o is then high in the cycle after Eh, so the next accept is at Eh+1 at the earliest. Minimum initiation interval is WIDTH+3 cycles.
- mul_ready_o and out_valid_o are never high in the same cycle.

## Test plan
- **Unsigned basic:** A=3, B=5, signed=00, out_ready_i=1.
  - Required: lo=15, hi=0.
  - out_valid_o rises exactly 65 edges after accept and is high for 1 cycle.
  - mul_ready_o is high again on the following cycle.
- **Sign modes:** A=B=0xFFFF_FFFF_FFFF_FFFF.
  - signed=11: hi=0, lo=1.
  - signed=00: hi=0xFFFF_FFFF_FFFF_FFFE, lo=1.
  - signed=10 with B=2: hi=0xFFFF_FFFF_FFFF_FFFF, lo=0xFFFF_FFFF_FFFF_FFFE.
- **Corner values:**
  - A=B=0x8000_0000_0000_0000, signed=11: hi=0x4000_0000_0000_0000, lo=0.
  - A=0, B=any: hi=lo=0, still 65-cycle latency.
- **Backpressure:** out_ready_i held low 5 cycles after out_valid_o rises.
  - Required: result stays stable and out_valid_o stays high.
  - mul_ready_o stays 0 and a new mul_valid_i is not accepted.
  - Handshake on cycle 6, then IDLE.
- **Flush:**
  - flush_i for 1 cycle at CALC cycle 10: out_valid_o never asserts and mul_ready_o is 1 the next cycle. A following 7×9 request returns lo=63.
  - flush_i coincident with mul_valid_i in IDLE: the request is not accepted.
- **Reset mid-op:** rst_i for 1 cycle at CALC cycle 30.
  - Required: all outputs return to 0 and no out_valid_o appears.
  - A subsequent −2×3 (signed=11) returns hi=0xFFFF_FFFF_FFFF_FFFF, lo=0xFFFF_FFFF_FFFF_FFFA.
